// File: rtl/dram_req_scheduler_if.sv
// Request, grant and refresh handshake bundle between requesters/controller and the scheduler.
// Latency: none (wires only).
// Backpressure: none here; the scheduler holds grant until ctrl_done and refresh_flag until refresh_ack.
interface dram_req_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int BW      = 3,
  parameter int RW      = 7,
  parameter int CW      = 3
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*BW-1:0] req_bank;
  logic [NUM_REQ*RW-1:0] req_row;
  logic [NUM_REQ*CW-1:0] req_col;
  logic [NUM_REQ-1:0]    grant;
  logic                  addr_val;
  logic [BW-1:0]         bank_id;
  logic [RW-1:0]         row_id;
  logic [CW-1:0]         col_id;
  logic                  ctrl_done;
  logic                  refresh_flag;
  logic                  refresh_ack;
  logic [3:0]            pending_refresh;
  logic                  refresh_overflow;

  // Requesters and the memory controller drive the request side.
  modport master (
    output req, req_bank, req_row, req_col, ctrl_done, refresh_ack,
    input  grant, addr_val, bank_id, row_id, col_id,
           refresh_flag, pending_refresh, refresh_overflow
  );

  // The scheduler drives grant, the latched address and refresh status.
  modport slave (
    input  req, req_bank, req_row, req_col, ctrl_done, refresh_ack,
    output grant, addr_val, bank_id, row_id, col_id,
           refresh_flag, pending_refresh, refresh_overflow
  );
endinterface

// File: rtl/dram_req_scheduler.sv
// Round-robin DRAM access scheduler with postponable periodic refresh (IDLE/ACCESS/REFRESH).
// Latency: grant/addr_val one cycle after req is seen in IDLE; at least one IDLE cycle between operations.
// Backpressure: grant held until ctrl_done; refresh_flag held until refresh_ack; refreshes owed up to MAX_POSTPONE.
module dram_req_scheduler #(
  parameter int NUMBER_OF_BANKS  = 8,
  parameter int NUMBER_OF_ROWS   = 128,
  parameter int NUMBER_OF_COLS   = 8,
  parameter int NUM_REQ          = 4,
  parameter int REFRESH_INTERVAL = 780,
  parameter int MAX_POSTPONE     = 8
) (
  input logic           clk,
  input logic           rst_b,
  dram_req_scheduler_if.slave bus
);
  localparam int BW = $clog2(NUMBER_OF_BANKS);
  localparam int RW = $clog2(NUMBER_OF_ROWS);
  localparam int CW = $clog2(NUMBER_OF_COLS);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(REFRESH_INTERVAL);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]    PEND_MAX   = 4'(MAX_POSTPONE);

  typedef enum logic [1:0] {IDLE, ACCESS, REFRESH} state_t;

  state_t               state;
  logic [TW-1:0]        timer;
  logic                 tick;
  logic                 ack_now;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        cur_idx;
  logic [IW-1:0]        cand;
  logic [IW-1:0]        win_idx;
  logic                 win_vld;
  logic [BW-1:0]        win_bank;
  logic [RW-1:0]        win_row;
  logic [CW-1:0]        win_col;
  logic [NUM_REQ-1:0]   grant_q;
  logic                 addr_val_q;
  logic                 refresh_flag_q;
  logic [BW-1:0]        bank_q;
  logic [RW-1:0]        row_q;
  logic [CW-1:0]        col_q;
  logic [3:0]           pend_q;
  logic                 ovf_q;

  assign tick    = (timer == '0);
  assign ack_now = (state == REFRESH) && bus.refresh_ack;

  // Refresh interval timer: counts down, ticks for the one cycle it sits at zero, then reloads.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b)     timer <= TIMER_LOAD;
    else if (tick) timer <= TIMER_LOAD;
    else           timer <= timer - 1'b1;
  end

  // Round-robin pick: scan downward so the nearest set bit at or after rr_ptr is written last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Select the winning requester's address fields from the packed request buses.
  always_comb begin
    win_bank = '0;
    win_row  = '0;
    win_col  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_bank = bus.req_bank[i*BW +: BW];
        win_row  = bus.req_row[i*RW +: RW];
        win_col  = bus.req_col[i*CW +: CW];
      end
    end
  end

  // Scheduler FSM with registered outputs and owed-refresh bookkeeping.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state          <= IDLE;
      grant_q        <= '0;
      addr_val_q     <= 1'b0;
      refresh_flag_q <= 1'b0;
      bank_q         <= '0;
      row_q          <= '0;
      col_q          <= '0;
      rr_ptr         <= '0;
      cur_idx        <= '0;
      pend_q         <= '0;
      ovf_q          <= 1'b0;
    end else begin
      // A tick and a completed refresh in the same cycle cancel out.
      if (tick && !ack_now) begin
        if (pend_q == PEND_MAX) ovf_q  <= 1'b1;
        else                    pend_q <= pend_q + 4'd1;
      end else if (ack_now && !tick) begin
        pend_q <= pend_q - 4'd1;
      end

      case (state)
        IDLE: begin
          if (pend_q == PEND_MAX) begin
            state          <= REFRESH;
            refresh_flag_q <= 1'b1;
          end else if (win_vld) begin
            state      <= ACCESS;
            grant_q    <= NUM_REQ'(1) << win_idx;
            addr_val_q <= 1'b1;
            cur_idx    <= win_idx;
            bank_q     <= win_bank;
            row_q      <= win_row;
            col_q      <= win_col;
          end else if (pend_q != 4'd0) begin
            state          <= REFRESH;
            refresh_flag_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (bus.ctrl_done) begin
            state      <= IDLE;
            grant_q    <= '0;
            addr_val_q <= 1'b0;
            rr_ptr     <= (cur_idx == IW'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;
          end
        end
        REFRESH: begin
          if (bus.refresh_ack) begin
            state          <= IDLE;
            refresh_flag_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant            = grant_q;
  assign bus.addr_val         = addr_val_q;
  assign bus.refresh_flag     = refresh_flag_q;
  assign bus.bank_id          = bank_q;
  assign bus.row_id           = row_q;
  assign bus.col_id           = col_q;
  assign bus.pending_refresh  = pend_q;
  assign bus.refresh_overflow = ovf_q;
endmodule
